// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: byte-serial program loader (IDLE -> LOAD -> READY)
// and a one-cycle-latency fetch port answering PC byte addresses in READY.
module instr_mem_responder #(
  parameter int          DEPTH_LOG2 = 8,
  parameter logic [31:0] HALT_WORD  = 32'hFFFFFFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_overflow,
  output logic [DEPTH_LOG2:0]   load_words,
  input  logic                  fetch_en,
  input  logic [31:0]           fetch_addr,
  output logic [31:0]           instr_out,
  output logic                  instr_valid,
  output logic                  addr_error,
  output logic                  halt_seen
);

  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LAST_IDX = (DEPTH_LOG2 + 1)'(DEPTH - 1);
  localparam logic [DEPTH_LOG2:0] ONE_W    = (DEPTH_LOG2 + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [1:0]            r_byte_cnt;
  logic [23:0]           r_asm;
  logic [DEPTH_LOG2:0]   r_load_words;
  logic                  r_overflow;
  logic                  r_halt_loaded;
  logic                  r_busy;
  logic                  r_done;
  logic [31:0]           r_instr;
  logic                  r_valid;
  logic                  r_err;
  logic                  r_halt_seen;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_clear;
  logic                  w_wr_en;
  logic                  w_shift;
  logic                  w_set_overflow;
  logic [31:0]           w_word;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_fetch_err;
  logic                  w_is_last;
  logic                  w_fetch_halt;

  assign w_word = {r_asm, byte_data};
  assign w_idx  = fetch_addr[DEPTH_LOG2+1:2];

  // Fetch address decode: misaligned, beyond the memory, or beyond the loaded program.
  always_comb begin
    w_fetch_err = 1'b0;
    w_is_last   = 1'b0;
    if ((fetch_addr[1:0] != 2'b00) || (|fetch_addr[31:DEPTH_LOG2+2]) ||
        ({1'b0, w_idx} >= r_load_words)) begin
      w_fetch_err = 1'b1;
    end else begin
      w_fetch_err = 1'b0;
    end
    if ({1'b0, w_idx} == (r_load_words - ONE_W)) begin
      w_is_last = 1'b1;
    end else begin
      w_is_last = 1'b0;
    end
  end

  // A load stops at the first HALT_WORD, so it can only ever sit in the last loaded slot.
  assign w_fetch_halt = (r_state == ST_READY) && fetch_en && !w_fetch_err &&
                        r_halt_loaded && w_is_last;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and loader control.
  always_comb begin
    w_next_state   = r_state;
    w_clear        = 1'b0;
    w_wr_en        = 1'b0;
    w_shift        = 1'b0;
    w_set_overflow = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (load_start) begin
          w_next_state = ST_LOAD;
          w_clear      = 1'b1;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (load_start) begin
          w_clear = 1'b1;
        end else if (byte_valid) begin
          if (r_byte_cnt == 2'd3) begin
            w_wr_en = 1'b1;
            if (w_word == HALT_WORD) begin
              w_next_state = ST_READY;
            end else if (r_load_words == LAST_IDX) begin
              w_next_state   = ST_READY;
              w_set_overflow = 1'b1;
            end else begin
              w_next_state = ST_LOAD;
            end
          end else begin
            w_shift = 1'b1;
          end
        end else begin
          w_next_state = ST_LOAD;
        end
      end
      ST_READY: begin
        if (load_start) begin
          w_next_state = ST_LOAD;
          w_clear      = 1'b1;
        end else begin
          w_next_state = ST_READY;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Loader datapath: byte assembly, word count and load status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte_cnt    <= 2'd0;
      r_asm         <= 24'd0;
      r_load_words  <= '0;
      r_overflow    <= 1'b0;
      r_halt_loaded <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_busy <= (w_next_state == ST_LOAD);
      r_done <= (r_state == ST_LOAD) && (w_next_state == ST_READY);
      if (w_clear) begin
        r_byte_cnt    <= 2'd0;
        r_asm         <= 24'd0;
        r_load_words  <= '0;
        r_overflow    <= 1'b0;
        r_halt_loaded <= 1'b0;
      end else if (w_wr_en) begin
        r_byte_cnt    <= 2'd0;
        r_asm         <= 24'd0;
        r_load_words  <= r_load_words + ONE_W;
        r_overflow    <= w_set_overflow;
        r_halt_loaded <= (w_word == HALT_WORD);
      end else if (w_shift) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        r_asm      <= {r_asm[15:0], byte_data};
      end else begin
        r_byte_cnt <= r_byte_cnt;
      end
    end
  end

  // Memory write port, used only while loading.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_load_words[DEPTH_LOG2-1:0]] <= w_word;
    end else begin
      r_mem[r_load_words[DEPTH_LOG2-1:0]] <= r_mem[r_load_words[DEPTH_LOG2-1:0]];
    end
  end

  // Registered fetch response; a stall holds the last instruction and error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr <= 32'd0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (r_state == ST_READY) begin
      if (fetch_en) begin
        r_valid <= 1'b1;
        if (w_fetch_err) begin
          r_instr <= 32'd0;
          r_err   <= 1'b1;
        end else begin
          r_instr <= r_mem[w_idx];
          r_err   <= 1'b0;
        end
      end else begin
        r_valid <= 1'b0;
      end
    end else begin
      r_instr <= 32'd0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end
  end

  // Sticky halt flag; a new load clears it even if a halting fetch lands in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_halt_seen <= 1'b0;
    end else if (w_clear) begin
      r_halt_seen <= 1'b0;
    end else if (w_fetch_halt) begin
      r_halt_seen <= 1'b1;
    end else begin
      r_halt_seen <= r_halt_seen;
    end
  end

  assign load_busy     = r_busy;
  assign load_done     = r_done;
  assign load_overflow = r_overflow;
  assign load_words    = r_load_words;
  assign instr_out     = r_instr;
  assign instr_valid   = r_valid;
  assign addr_error    = r_err;
  assign halt_seen     = r_halt_seen;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Self-checking bench for instr_mem_responder: directed test-plan sequences, a fetch
// vector table, and randomized programs/fetches checked against a behavioural model.
module tb_instr_mem_responder;

  localparam logic [31:0] HALT = 32'hFFFFFFFF;
  localparam int          MEMW = 256;

  logic        clk = 1'b0;
  logic        reset, load_start, byte_valid, fetch_en;
  logic [7:0]  byte_data;
  logic [31:0] fetch_addr;
  logic        load_busy, load_done, load_overflow, instr_valid, addr_error, halt_seen;
  logic [8:0]  load_words;
  logic [31:0] instr_out;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  // Behavioural model state
  logic [31:0] m_mem [MEMW];
  int          m_words;
  logic        m_ovf;
  logic        m_halt;
  logic [31:0] m_instr;
  logic        m_err;
  logic [31:0] prog_q [$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_instr;
    logic        exp_err;
    logic        exp_halt;
  } vec_t;
  vec_t vecs [7];

  instr_mem_responder #(.DEPTH_LOG2(8), .HALT_WORD(32'hFFFFFFFF)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .byte_valid(byte_valid),
    .byte_data(byte_data), .load_busy(load_busy), .load_done(load_done),
    .load_overflow(load_overflow), .load_words(load_words), .fetch_en(fetch_en),
    .fetch_addr(fetch_addr), .instr_out(instr_out), .instr_valid(instr_valid),
    .addr_error(addr_error), .halt_seen(halt_seen)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (load_done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    tick();
    byte_valid = 1'b0;
  endtask

  // Load prog_q; the model stops at the first HALT or when memory is full.
  task automatic do_load();
    int n;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("load_busy_after_start", {31'd0, load_busy}, 32'd1);
    m_words = 0; m_ovf = 1'b0; m_halt = 1'b0;
    n = 0;
    foreach (prog_q[i]) begin
      for (int b = 3; b >= 0; b--) send_byte(prog_q[i][b*8 +: 8]);
      m_mem[m_words] = prog_q[i];
      m_words++;
      if (prog_q[i] == HALT) break;
      if (m_words == MEMW) begin
        m_ovf = 1'b1;
        break;
      end
    end
    chk("load_done_pulse", {31'd0, load_done}, 32'd1);
    chk("load_words", {23'd0, load_words}, 32'(m_words));
    chk("load_overflow", {31'd0, load_overflow}, {31'd0, m_ovf});
    chk("load_busy_after_load", {31'd0, load_busy}, 32'd0);
    m_instr = 32'd0; m_err = 1'b0;
  endtask

  // One fetch cycle (en=1) or stall (en=0), compared with the model.
  task automatic do_fetch(input logic en, input logic [31:0] addr);
    logic e;
    fetch_en   = en;
    fetch_addr = addr;
    tick();
    fetch_en = 1'b0;
    if (en) begin
      e = (addr % 4 != 0) || (addr >= 32'(MEMW * 4)) || (int'(addr / 4) >= m_words);
      m_err   = e;
      m_instr = e ? 32'd0 : m_mem[addr / 4];
      if (!e && m_instr == HALT) m_halt = 1'b1;
    end
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, en});
    chk("instr_out", instr_out, m_instr);
    chk("addr_error", {31'd0, addr_error}, {31'd0, m_err});
    chk("halt_seen", {31'd0, halt_seen}, {31'd0, m_halt});
  endtask

  initial begin
    int d0;
    logic [31:0] w, a, last_w;
    reset = 1'b1; load_start = 1'b0; byte_valid = 1'b0; byte_data = 8'd0;
    fetch_en = 1'b0; fetch_addr = 32'd0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_instr_out", instr_out, 32'd0);
    chk("rst_load_words", {23'd0, load_words}, 32'd0);
    chk("rst_flags", {26'd0, load_busy, load_done, load_overflow, instr_valid, addr_error, halt_seen}, 32'd0);

    // Fetch while IDLE is ignored
    fetch_en = 1'b1; fetch_addr = 32'd0; tick(); fetch_en = 1'b0;
    chk("idle_fetch_valid", {31'd0, instr_valid}, 32'd0);
    chk("idle_fetch_instr", instr_out, 32'd0);
    chk("idle_busy", {31'd0, load_busy}, 32'd0);

    // Test-plan program
    d0 = done_cnt;
    prog_q = '{32'h20080005, 32'h8C010004, 32'hFFFFFFFF};
    do_load();
    tick(); tick();
    chk("done_once", 32'(done_cnt - d0), 32'd1);

    vecs[0] = '{32'd0,         32'h20080005, 1'b0, 1'b0};
    vecs[1] = '{32'd4,         32'h8C010004, 1'b0, 1'b0};
    vecs[2] = '{32'd8,         32'hFFFFFFFF, 1'b0, 1'b1};
    vecs[3] = '{32'd12,        32'h00000000, 1'b1, 1'b1};
    vecs[4] = '{32'd2,         32'h00000000, 1'b1, 1'b1};
    vecs[5] = '{32'h00000400,  32'h00000000, 1'b1, 1'b1};
    vecs[6] = '{32'h80000000,  32'h00000000, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      fetch_en = 1'b1; fetch_addr = vecs[i].addr; tick(); fetch_en = 1'b0;
      chk($sformatf("vec%0d_valid", i), {31'd0, instr_valid}, 32'd1);
      chk($sformatf("vec%0d_instr", i), instr_out, vecs[i].exp_instr);
      chk($sformatf("vec%0d_err", i), {31'd0, addr_error}, {31'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_halt", i), {31'd0, halt_seen}, {31'd0, vecs[i].exp_halt});
    end
    m_halt = 1'b1;

    // Stall holds the last instruction
    do_fetch(1'b1, 32'd4);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_instr", instr_out, 32'h8C010004);
      chk("stall_valid", {31'd0, instr_valid}, 32'd0);
    end

    // load_start in READY with a same-cycle fetch: fetch still answered, halt_seen cleared
    load_start = 1'b1; fetch_en = 1'b1; fetch_addr = 32'd8; tick();
    load_start = 1'b0; fetch_en = 1'b0;
    chk("restart_fetch_valid", {31'd0, instr_valid}, 32'd1);
    chk("restart_fetch_instr", instr_out, 32'hFFFFFFFF);
    chk("restart_halt_clr", {31'd0, halt_seen}, 32'd0);
    chk("restart_busy", {31'd0, load_busy}, 32'd1);
    chk("restart_words_clr", {23'd0, load_words}, 32'd0);

    // Partial word, then restart with a dropped same-cycle byte, then fresh bytes
    send_byte(8'hAA); send_byte(8'hBB);
    load_start = 1'b1; byte_valid = 1'b1; byte_data = 8'hCC; tick();
    load_start = 1'b0; byte_valid = 1'b0;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    for (int i = 0; i < 4; i++) send_byte(8'hFF);
    chk("partial_words", {23'd0, load_words}, 32'd2);
    chk("partial_done", {31'd0, load_done}, 32'd1);
    m_mem[0] = 32'h11223344; m_mem[1] = HALT; m_words = 2; m_halt = 1'b0;
    m_instr = 32'd0; m_err = 1'b0;
    do_fetch(1'b1, 32'd0);
    do_fetch(1'b1, 32'd4);

    // Reset in the middle of a load
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(8'(i + 1));
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midrst_words", {23'd0, load_words}, 32'd0);
    chk("midrst_busy", {31'd0, load_busy}, 32'd0);
    fetch_en = 1'b1; fetch_addr = 32'd0; tick(); fetch_en = 1'b0;
    chk("midrst_fetch_valid", {31'd0, instr_valid}, 32'd0);

    // Full memory without HALT
    prog_q.delete();
    for (int i = 0; i < MEMW; i++) begin
      w = $urandom();
      if (w == HALT) w = 32'h0;
      prog_q.push_back(w);
    end
    last_w = prog_q[MEMW-1];
    m_halt = 1'b0;
    do_load();
    fetch_en = 1'b1; fetch_addr = 32'd1020; tick(); fetch_en = 1'b0;
    chk("ovf_last_word", instr_out, last_w);
    chk("ovf_last_err", {31'd0, addr_error}, 32'd0);
    fetch_en = 1'b1; fetch_addr = 32'd1024; tick(); fetch_en = 1'b0;
    chk("ovf_1024_err", {31'd0, addr_error}, 32'd1);
    chk("ovf_halt_seen", {31'd0, halt_seen}, 32'd0);
    chk("ovf_sticky", {31'd0, load_overflow}, 32'd1);

    // Randomized programs and fetches against the model
    for (int p = 0; p < 20; p++) begin
      prog_q.delete();
      for (int i = 0; i < int'($urandom_range(0, 39)); i++) begin
        w = $urandom();
        if (w == HALT) w = 32'h1;
        prog_q.push_back(w);
      end
      prog_q.push_back(HALT);
      do_load();
      for (int f = 0; f < 30; f++) begin
        case ($urandom_range(0, 5))
          0, 1: a = 32'($urandom_range(0, m_words - 1)) * 32'd4;
          2:    a = 32'($urandom_range(0, MEMW - 1)) * 32'd4;
          3:    a = (32'($urandom_range(0, m_words - 1)) * 32'd4) | 32'($urandom_range(1, 3));
          4:    a = $urandom();
          default: a = 32'(m_words - 1) * 32'd4;
        endcase
        do_fetch(($urandom_range(0, 3) != 0), a);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
